// File: rtl/ex_mdu_pkg.sv
// Shared execute-stage definitions for the multiply/divide unit: opcodes,
// bus widths, stall values and the MDU state encoding.
package ex_mdu_pkg;

    localparam int ALUOP_W = 8;
    localparam int REG_W   = 32;

    localparam logic [ALUOP_W-1:0] EXE_NOP_OP   = 8'b0000_0000;
    localparam logic [ALUOP_W-1:0] EXE_MULT_OP  = 8'b0001_1000;
    localparam logic [ALUOP_W-1:0] EXE_MULTU_OP = 8'b0001_1001;
    localparam logic [ALUOP_W-1:0] EXE_DIV_OP   = 8'b0001_1010;
    localparam logic [ALUOP_W-1:0] EXE_DIVU_OP  = 8'b0001_1011;

    localparam logic [REG_W-1:0] ZERO_WORD  = '0;
    localparam logic             RST_ENABLE = 1'b1;
    localparam logic             STOP       = 1'b1;
    localparam logic             NO_STOP    = 1'b0;

    typedef enum logic [2:0] {
        MDU_IDLE     = 3'd0,
        MDU_MUL      = 3'd1,
        MDU_DIV_ON   = 3'd2,
        MDU_DIV_ZERO = 3'd3,
        MDU_DONE     = 3'd4
    } mdu_state_e;

    // Two's-complement negate when neg is set; used for |x| and sign fix-up.
    function automatic logic [REG_W-1:0] neg_if(input logic neg, input logic [REG_W-1:0] v);
        return neg ? (ZERO_WORD - v) : v;
    endfunction

endpackage

// File: rtl/ex_mdu_div_core.sv
// Iterative radix-2 restoring divider on unsigned magnitudes: one quotient
// bit per step, with an iteration counter flagging the final step.
module mdu_div_core
    import ex_mdu_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             step_i,
    input  logic [REG_W-1:0] dividend_i,
    input  logic [REG_W-1:0] divisor_i,
    output logic [REG_W-1:0] quo_o,
    output logic [REG_W-1:0] rem_o,
    output logic             last_o
);

    localparam int CNT_W = $clog2(DIV_CYCLES);

    logic [REG_W-1:0] rem_q, rem_d;
    logic [REG_W-1:0] quo_q, quo_d;
    logic [REG_W-1:0] dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [REG_W:0]   trial;
    logic [REG_W:0]   diff;
    logic             ge;

    // One extra bit on the trial remainder: shifted value can reach 2*divisor-1.
    always_comb begin
        trial = {rem_q, quo_q[REG_W-1]};
        diff  = trial - {1'b0, dvs_q};
        ge    = ~diff[REG_W];
        rem_o = ge ? diff[REG_W-1:0] : trial[REG_W-1:0];
        quo_o = {quo_q[REG_W-2:0], ge};
    end

    assign last_o = (cnt_q == CNT_W'(DIV_CYCLES - 1));

    always_comb begin
        rem_d = rem_q;
        quo_d = quo_q;
        dvs_d = dvs_q;
        cnt_d = cnt_q;
        if (start_i) begin
            rem_d = ZERO_WORD;
            quo_d = dividend_i;
            dvs_d = divisor_i;
            cnt_d = '0;
        end else if (step_i) begin
            rem_d = rem_o;
            quo_d = quo_o;
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        rem_q <= rem_d;
        quo_q <= quo_d;
        dvs_q <= dvs_d;
    end

endmodule

// File: rtl/ex_mdu.sv
// Execute-stage multiply/divide unit: FSM, one-cycle multiply path, sign
// handling around the iterative divider, and the HI/LO write port.
module ex_mdu
    import ex_mdu_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ALUOP_W-1:0] aluop_i,
    input  logic [REG_W-1:0]   reg1_i,
    input  logic [REG_W-1:0]   reg2_i,
    input  logic               annul_i,
    output logic               stallreq_o,
    output logic               hilo_we_o,
    output logic [REG_W-1:0]   hi_o,
    output logic [REG_W-1:0]   lo_o
);

    localparam int MSB = REG_W - 1;

    mdu_state_e         state_q, state_d;
    logic [REG_W-1:0]   res_hi_q, res_hi_d, res_lo_q, res_lo_d;
    logic [REG_W-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
    logic               is_mul, is_div, is_signed, div_by_zero, issue;
    logic [2*REG_W-1:0] mul_a, mul_b, product;
    logic               div_start, div_step, div_last;
    logic [REG_W-1:0]   div_quo, div_rem;

    assign is_mul      = (aluop_i == EXE_MULT_OP) || (aluop_i == EXE_MULTU_OP);
    assign is_div      = (aluop_i == EXE_DIV_OP)  || (aluop_i == EXE_DIVU_OP);
    assign is_signed   = (aluop_i == EXE_MULT_OP) || (aluop_i == EXE_DIV_OP);
    assign div_by_zero = (reg2_i == ZERO_WORD);
    assign issue       = (state_q == MDU_IDLE) && (is_mul || is_div) && !annul_i;

    // Low 64 bits of the extended product equal the signed/unsigned 32x32 product.
    assign mul_a   = is_signed ? {{REG_W{reg1_i[MSB]}}, reg1_i} : {ZERO_WORD, reg1_i};
    assign mul_b   = is_signed ? {{REG_W{reg2_i[MSB]}}, reg2_i} : {ZERO_WORD, reg2_i};
    assign product = mul_a * mul_b;

    assign div_start = issue && is_div && !div_by_zero;
    assign div_step  = (state_q == MDU_DIV_ON) && !annul_i;

    mdu_div_core #(.DIV_CYCLES(DIV_CYCLES)) u_div (
        .clk        (clk),
        .rst        (rst),
        .start_i    (div_start),
        .step_i     (div_step),
        .dividend_i (neg_if(is_signed && reg1_i[MSB], reg1_i)),
        .divisor_i  (neg_if(is_signed && reg2_i[MSB], reg2_i)),
        .quo_o      (div_quo),
        .rem_o      (div_rem),
        .last_o     (div_last)
    );

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state_q <= MDU_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (annul_i) begin
            state_d = MDU_IDLE;
        end else begin
            case (state_q)
                MDU_IDLE: begin
                    if (is_mul)      state_d = MDU_MUL;
                    else if (is_div) state_d = div_by_zero ? MDU_DIV_ZERO : MDU_DIV_ON;
                end
                MDU_MUL:      state_d = MDU_IDLE;
                MDU_DIV_ON:   if (div_last) state_d = MDU_DONE;
                MDU_DIV_ZERO: state_d = MDU_DONE;
                MDU_DONE:     state_d = MDU_IDLE;
                default:      state_d = MDU_IDLE;
            endcase
        end
    end

    always_comb begin
        stallreq_o = NO_STOP;
        hilo_we_o  = 1'b0;
        case (state_q)
            MDU_IDLE:                 stallreq_o = issue ? STOP : NO_STOP;
            MDU_DIV_ON, MDU_DIV_ZERO: stallreq_o = annul_i ? NO_STOP : STOP;
            MDU_MUL, MDU_DONE:        hilo_we_o  = !annul_i;
            default:                  stallreq_o = NO_STOP;
        endcase
    end

    // Pending result: product or div-by-zero value at issue, quotient/remainder on the last step.
    always_comb begin
        res_hi_d  = res_hi_q;
        res_lo_d  = res_lo_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        if (issue) begin
            if (is_mul) begin
                {res_hi_d, res_lo_d} = product;
            end else if (div_by_zero) begin
                res_hi_d = reg1_i;
                res_lo_d = '1;
            end else begin
                neg_quo_d = is_signed && (reg1_i[MSB] ^ reg2_i[MSB]);
                neg_rem_d = is_signed && reg1_i[MSB];
            end
        end else if (div_step && div_last) begin
            res_lo_d = neg_if(neg_quo_q, div_quo);
            res_hi_d = neg_if(neg_rem_q, div_rem);
        end
    end

    always_ff @(posedge clk) begin
        res_hi_q  <= res_hi_d;
        res_lo_q  <= res_lo_d;
        neg_quo_q <= neg_quo_d;
        neg_rem_q <= neg_rem_d;
    end

    assign hi_d = hilo_we_o ? res_hi_q : hi_q;
    assign lo_d = hilo_we_o ? res_lo_q : lo_q;
    assign hi_o = hi_d;
    assign lo_o = lo_d;

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            hi_q <= ZERO_WORD;
            lo_q <= ZERO_WORD;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

endmodule
